// File: rtl/fir_coef_loader.sv
// Coefficient download sequencer for the FIR filter bank: turns an SPI byte stream
// (MSB then LSB) into per-filter RAM write pulses, holding audio off while busy.
module fir_coef_loader #(
  parameter int NUM_FILTERS = 4,   // 1..64
  parameter int SETTLE_CLKS = 2    // >= 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       audio_en_in,
  input  logic [8:0] coefs_per_tap,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       wr_addr_zero,
  output logic       coef_addr_rst,
  output logic       coefficient_wr_en,
  output logic [5:0] coef_select,
  output logic [7:0] coef_wr_msb_data,
  output logic [7:0] coef_wr_lsb_data,
  output logic       audio_en_out,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int         SW     = (SETTLE_CLKS > 1) ? $clog2(SETTLE_CLKS) : 1;
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CLKS - 1);
  localparam logic [5:0] FILT_LAST = 6'(NUM_FILTERS - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR_RST, ADDR_CHK, GET_MSB, GET_LSB, WRITE, SETTLE, NEXT, DONE, ERROR
  } state_t;

  state_t        state;
  logic [5:0]    filt_idx;
  logic [8:0]    coef_cnt;
  logic [8:0]    n_lat;
  logic [SW-1:0] settle_cnt;
  logic [7:0]    msb_q, lsb_q;
  logic          done_q, error_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      filt_idx   <= '0;
      coef_cnt   <= '0;
      n_lat      <= '0;
      settle_cnt <= '0;
      msb_q      <= '0;
      lsb_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // abort outranks everything, including a byte transfer in the same clk
      if (busy && abort) begin
        state   <= ERROR;
        error_q <= 1'b1;
      end else begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (start) begin
              error_q  <= 1'b0;
              filt_idx <= '0;
              coef_cnt <= '0;
              n_lat    <= coefs_per_tap;
              if (coefs_per_tap == '0) begin
                state   <= ERROR;
                error_q <= 1'b1;
              end else begin
                state <= ADDR_RST;
              end
            end
          end
          ADDR_RST: state <= ADDR_CHK;
          ADDR_CHK: begin
            if (wr_addr_zero) state <= GET_MSB;
            else begin
              state   <= ERROR;
              error_q <= 1'b1;
            end
          end
          GET_MSB: if (byte_valid) begin
            msb_q <= byte_in;
            state <= GET_LSB;
          end
          GET_LSB: if (byte_valid) begin
            lsb_q <= byte_in;
            state <= WRITE;
          end
          WRITE: begin
            coef_cnt   <= coef_cnt + 9'd1;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
          SETTLE: begin
            if (settle_cnt == SET_LAST)
              state <= (coef_cnt < n_lat) ? GET_MSB : NEXT;
            else
              settle_cnt <= settle_cnt + 1'b1;
          end
          NEXT: begin
            if (filt_idx == FILT_LAST) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              filt_idx <= filt_idx + 6'd1;
              coef_cnt <= '0;
              state    <= ADDR_RST;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Moore outputs decoded straight from the state register
  assign busy              = !(state inside {IDLE, DONE, ERROR});
  assign byte_ready        = (state == GET_MSB) || (state == GET_LSB);
  assign coef_addr_rst     = (state == ADDR_RST);
  assign coefficient_wr_en = (state == WRITE);
  assign coef_select       = filt_idx;
  assign coef_wr_msb_data  = msb_q;
  assign coef_wr_lsb_data  = lsb_q;
  assign done              = done_q;
  assign error             = error_q;
  assign audio_en_out      = audio_en_in & ~busy;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Randomized bench for fir_coef_loader: models the coefficient bank and derives the
// expected write sequence from the accepted byte stream.
module tb_fir_coef_loader;
  localparam int NF = 4;
  localparam int SC = 2;

  logic       clk = 0, reset_n = 0, start = 0, abort = 0, audio_en_in = 0;
  logic [8:0] coefs_per_tap = '0;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 0, wr_addr_zero = 1;
  logic       byte_ready, coef_addr_rst, coefficient_wr_en, audio_en_out, busy, done, error;
  logic [5:0] coef_select;
  logic [7:0] coef_wr_msb_data, coef_wr_lsb_data;

  always #5 clk = ~clk;

  fir_coef_loader #(.NUM_FILTERS(NF), .SETTLE_CLKS(SC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .audio_en_in(audio_en_in), .coefs_per_tap(coefs_per_tap),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wr_addr_zero(wr_addr_zero), .coef_addr_rst(coef_addr_rst),
    .coefficient_wr_en(coefficient_wr_en), .coef_select(coef_select),
    .coef_wr_msb_data(coef_wr_msb_data), .coef_wr_lsb_data(coef_wr_lsb_data),
    .audio_en_out(audio_en_out), .busy(busy), .done(done), .error(error)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  byte_q[$];
  logic [21:0] wr_q[$];
  logic [15:0] ram [NF][512];
  int n_rst, n_done, audio_bad, stab_bad, rdy_bad;
  int vmode = 0, addr = 0, hold = 0;
  bit fixed_data = 0, force_nz = 0, bank_pend = 0;
  logic [21:0] snap = '0;

  // byte source, bank model and protocol monitor
  initial forever begin
    @(negedge clk);
    audio_en_in = 1'($urandom_range(0, 1));
    byte_valid  = (vmode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    byte_in     = fixed_data ? ((byte_q.size() % 2 == 0) ? 8'h12 : 8'h34) : 8'($urandom);
    #2;
    if (byte_valid && byte_ready && reset_n && !(abort && busy)) byte_q.push_back(byte_in);
    if (busy && audio_en_out) audio_bad++;
    if (!busy && audio_en_out !== audio_en_in) audio_bad++;
    if (coef_addr_rst) n_rst++;
    if (done) n_done++;
    if (bank_pend) begin
      if (snap[21:16] < NF && addr < 512) ram[snap[21:16]][addr] = {coef_wr_msb_data, coef_wr_lsb_data};
      addr++;
      bank_pend = 0;
    end
    if (hold > 0) begin
      if ({coef_select, coef_wr_msb_data, coef_wr_lsb_data} !== snap || byte_ready) stab_bad++;
      hold--;
    end
    if (coefficient_wr_en) begin
      snap = {coef_select, coef_wr_msb_data, coef_wr_lsb_data};
      wr_q.push_back(snap);
      hold = SC;
      bank_pend = 1;
      if (byte_ready) rdy_bad++;
    end
    if (coef_addr_rst) addr = 0;
    wr_addr_zero = force_nz ? 1'b0 : (addr == 0);
  end

  task automatic kick(input int n, input bit with_abort);
    @(negedge clk); #1;
    byte_q.delete(); wr_q.delete();
    n_rst = 0; n_done = 0; audio_bad = 0; stab_bad = 0; rdy_bad = 0;
    coefs_per_tap = 9'(n);
    start = 1; abort = with_abort;
    @(negedge clk); #1;
    start = 0; abort = 0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!busy) break;
      @(negedge clk); #3;
    end
    chk("timeout", 32'(i < budget), 1);
  endtask

  // expected write k is bytes 2k/2k+1 of the accepted stream, for filter k/n
  task automatic check_run(input string tag, input int n, input bit complete);
    int exp_n, bad, rbad;
    logic [21:0] e;
    exp_n = complete ? NF * n : byte_q.size() / 2;
    bad = 0; rbad = 0;
    chk({tag, ".nwr"}, wr_q.size(), exp_n);
    for (int k = 0; k < exp_n && k < wr_q.size() && 2 * k + 1 < byte_q.size(); k++) begin
      e = {6'(k / n), byte_q[2 * k], byte_q[2 * k + 1]};
      if (wr_q[k] !== e) bad++;
      if (complete && ram[k / n][k % n] !== e[15:0]) rbad++;
    end
    chk({tag, ".wrdata"}, bad, 0);
    chk({tag, ".stable"}, stab_bad, 0);
    chk({tag, ".rdy"}, rdy_bad, 0);
    chk({tag, ".audio"}, audio_bad, 0);
    if (complete) begin
      chk({tag, ".ram"}, rbad, 0);
      chk({tag, ".nrst"}, n_rst, NF);
      chk({tag, ".ndone"}, n_done, 1);
      chk({tag, ".err"}, error, 0);
    end
  endtask

  initial begin
    int n, nw;
    bit found;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.error", error, 0);
    chk("rst.rdy", byte_ready, 0);
    chk("rst.outs", {coefficient_wr_en, coef_addr_rst, coef_select, coef_wr_msb_data, coef_wr_lsb_data}, 0);
    chk("rst.audio", audio_en_out, audio_en_in);
    reset_n = 1;

    kick(3, 0); wait_idle(2000); check_run("n3", 3, 1);

    fixed_data = 1;
    kick(2, 0); wait_idle(2000); check_run("fix", 2, 1);
    chk("fix.first", wr_q.size() > 0 ? 32'(wr_q[0]) : 32'hFFFF_FFFF, 32'h1234);
    fixed_data = 0;

    vmode = 1;
    n = $urandom_range(1, 6);
    kick(n, 0);
    repeat (15) @(negedge clk);
    #1 start = 1;
    @(negedge clk); #1 start = 0;
    wait_idle(5000); check_run("sparse", n, 1);
    vmode = 0;

    force_nz = 1;
    kick(3, 0); wait_idle(50);
    chk("nz.err", error, 1);
    chk("nz.busy", busy, 0);
    chk("nz.nwr", wr_q.size(), 0);
    chk("nz.audio", audio_bad, 0);
    force_nz = 0;

    kick(3, 0);
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk); #1;
      if (coef_select == 2 && byte_ready && byte_q.size() % 2 == 1) found = 1;
    end
    chk("abort.found", found, 1);
    abort = 1;
    @(negedge clk); #1 abort = 0;
    chk("abort.err", error, 1);
    chk("abort.busy", busy, 0);
    nw = wr_q.size();
    repeat (20) @(negedge clk);
    chk("abort.nomore", wr_q.size(), nw);
    check_run("abort", 3, 0);

    kick(3, 1); wait_idle(2000); check_run("reload", 3, 1);

    kick(0, 0); wait_idle(20);
    chk("zero.err", error, 1);
    chk("zero.nrst", n_rst, 0);
    chk("zero.nwr", wr_q.size(), 0);

    kick(4, 0);
    repeat (30) @(negedge clk);
    #1 reset_n = 0;
    @(negedge clk); #1;
    chk("mrst.busy", busy, 0);
    chk("mrst.err", error, 0);
    chk("mrst.wr", coefficient_wr_en, 0);
    nw = wr_q.size();
    repeat (5) @(negedge clk);
    chk("mrst.nomore", wr_q.size(), nw);
    reset_n = 1;

    kick(511, 0); wait_idle(30000); check_run("n511", 511, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
